// File: rtl/fft_stage_sequencer.sv
// Radix-2 DIF FFT scheduler: walks LOG2N stages of N/2 butterflies over one dual-port RAM,
// issuing read/twiddle addresses and replaying them RD_LAT cycles later as butterfly/write strobes.
module fft_stage_sequencer #(
    parameter int LOG2N  = 8,
    parameter int RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOG2N)-1:0]   stage,
    output logic                       rd_en,
    output logic [LOG2N-1:0]           rd_addr_a,
    output logic [LOG2N-1:0]           rd_addr_b,
    output logic [LOG2N-2:0]           tw_addr,
    output logic                       bf_en,
    output logic                       wr_en,
    output logic [LOG2N-1:0]           wr_addr_a,
    output logic [LOG2N-1:0]           wr_addr_b
);

    localparam int SW = $clog2(LOG2N);
    localparam int DW = $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_n;
    logic [SW-1:0]      stage_n;
    logic [LOG2N-2:0]   k, k_n;
    logic [DW-1:0]      drain, drain_n;

    logic [LOG2N-1:0]   kext, low_mask, span_bit, base_a, tw_full;

    logic               en_pipe [RD_LAT];
    logic [LOG2N-1:0]   wa_pipe [RD_LAT];
    logic [LOG2N-1:0]   wb_pipe [RD_LAT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            stage <= '0;
            k     <= '0;
            drain <= '0;
        end else begin
            state <= state_n;
            stage <= stage_n;
            k     <= k_n;
            drain <= drain_n;
        end
    end

    always_comb begin
        state_n = state;
        stage_n = stage;
        k_n     = k;
        drain_n = drain;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RUN;
                    stage_n = '0;
                    k_n     = '0;
                end
            end
            S_RUN: begin
                if (k == '1) begin
                    state_n = S_DRAIN;
                    drain_n = DW'(RD_LAT);
                end else begin
                    k_n = k + 1'b1;
                end
            end
            S_DRAIN: begin
                // Hold off the next stage until the last write of this one has landed
                if (drain == DW'(1)) begin
                    if (stage == SW'(LOG2N - 1)) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_RUN;
                        stage_n = stage + 1'b1;
                        k_n     = '0;
                    end
                end else begin
                    drain_n = drain - 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
                stage_n = '0;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Insert a 0 (leg a) or 1 (leg b) at bit p = LOG2N-1-stage of k; low bits of k scale the twiddle
    always_comb begin
        kext     = {1'b0, k};
        low_mask = '0;
        span_bit = '0;
        for (int i = 0; i < LOG2N; i++) begin
            low_mask[i] = (i + int'(stage)) < (LOG2N - 1);
            span_bit[i] = (i + int'(stage)) == (LOG2N - 1);
        end
        base_a  = ((kext & ~low_mask) << 1) | (kext & low_mask);
        tw_full = (kext & low_mask) << stage;
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign rd_en     = (state == S_RUN);
    assign rd_addr_a = rd_en ? base_a : '0;
    assign rd_addr_b = rd_en ? (base_a | span_bit) : '0;
    assign tw_addr   = rd_en ? tw_full[LOG2N-2:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                en_pipe[i] <= 1'b0;
                wa_pipe[i] <= '0;
                wb_pipe[i] <= '0;
            end
        end else begin
            en_pipe[0] <= rd_en;
            wa_pipe[0] <= rd_addr_a;
            wb_pipe[0] <= rd_addr_b;
            for (int i = 1; i < RD_LAT; i++) begin
                en_pipe[i] <= en_pipe[i-1];
                wa_pipe[i] <= wa_pipe[i-1];
                wb_pipe[i] <= wb_pipe[i-1];
            end
        end
    end

    assign bf_en     = en_pipe[RD_LAT-1];
    assign wr_en     = en_pipe[RD_LAT-1];
    assign wr_addr_a = wa_pipe[RD_LAT-1];
    assign wr_addr_b = wb_pipe[RD_LAT-1];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: full-transform trace against a timing model,
// async abort, back-to-back starts, and an RD_LAT=1 instance.
module tb_fft_stage_sequencer;

    localparam int N2     = 128;
    localparam int PER    = 130;
    localparam int DONE_C = 1041;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;

    logic       busy, done, rd_en, bf_en, wr_en;
    logic [2:0] stage;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_addr;

    logic       busy1, done1, rd_en1, bf_en1, wr_en1;
    logic [2:0] stage1;
    logic [7:0] rd_addr_a1, rd_addr_b1, wr_addr_a1, wr_addr_b1;
    logic [6:0] tw_addr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fft_stage_sequencer #(.LOG2N(8), .RD_LAT(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .stage(stage),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bf_en(bf_en), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );

    fft_stage_sequencer #(.LOG2N(8), .RD_LAT(1)) u_dut_lat1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .stage(stage1),
        .rd_en(rd_en1), .rd_addr_a(rd_addr_a1), .rd_addr_b(rd_addr_b1), .tw_addr(tw_addr1),
        .bf_en(bf_en1), .wr_en(wr_en1), .wr_addr_a(wr_addr_a1), .wr_addr_b(wr_addr_b1)
    );

    // Expected issue-side outputs for cycle c counted from the accepting edge (c=0)
    function automatic void model(input int c, output logic en, output logic [7:0] a,
                                  output logic [7:0] b, output logic [6:0] tw, output logic [2:0] st);
        int s, off, p, low;
        en = 1'b0; a = '0; b = '0; tw = '0; st = '0;
        if (c >= 1 && c <= 8 * PER) begin
            s   = (c - 1) / PER;
            off = (c - 1) % PER;
            st  = 3'(s);
            if (off < N2) begin
                p   = 7 - s;
                low = off % (1 << p);
                en  = 1'b1;
                a   = 8'((off >> p) * (1 << (p + 1)) + low);
                b   = 8'(int'(a) + (1 << p));
                tw  = 7'(low << s);
            end
        end else if (c == DONE_C) begin
            st = 3'd7;
        end
    endfunction

    function automatic int cm_of(input int c, input bit hold);
        if (c < 1) return 0;
        if (hold && c >= DONE_C + 1) return c - (DONE_C + 1);
        return c;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_en, wr_en, wr_addr_a, wr_addr_b} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: busy=%0b done=%0b rd_en=%0b a=%0d b=%0d wr_en=%0b, required all 0",
                     busy, done, rd_en, rd_addr_a, rd_addr_b, wr_en);
        end
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || rd_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_no_start: busy=%0b rd_en=%0b, required 0 0", busy, rd_en);
        end
    endtask

    task automatic run_trace(input bit hold, input string name);
        logic       e_en, w_en;
        logic [7:0] e_a, e_b, w_a, w_b;
        logic [6:0] e_tw, w_tw;
        logic [2:0] e_st, w_st;
        logic [46:0] got, exp;
        int bad = 0, first_bad = -1, wr_cnt = 0, done_cnt = 0, cm;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= DONE_C + 4; c++) begin
            cm = cm_of(c, hold);
            model(cm, e_en, e_a, e_b, e_tw, e_st);
            model(cm_of(c - 2, hold), w_en, w_a, w_b, w_tw, w_st);
            exp = {e_en, e_a, e_b, e_tw, e_st, w_en, w_en, w_a, w_b,
                   (cm >= 1 && cm <= DONE_C), (cm == DONE_C)};
            got = {rd_en, rd_addr_a, rd_addr_b, tw_addr, stage, bf_en, wr_en, wr_addr_a, wr_addr_b, busy, done};
            if (got !== exp) begin
                bad++;
                if (first_bad < 0) first_bad = c;
            end
            if (wr_en === 1'b1) wr_cnt++;
            if (done === 1'b1) done_cnt++;
            if (c == 1) begin
                checks++;
                if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== {1'b1, 8'd0, 8'd128, 7'd0}) begin
                    errors++;
                    $display("[TB] FAIL %s first_read: en=%0b a=%0d b=%0d tw=%0d, required 1 0 128 0",
                             name, rd_en, rd_addr_a, rd_addr_b, tw_addr);
                end
            end
            if (c == 2) begin
                checks++;
                if ({rd_en, rd_addr_a, rd_addr_b, tw_addr} !== {1'b1, 8'd1, 8'd129, 7'd1}) begin
                    errors++;
                    $display("[TB] FAIL %s second_read: en=%0b a=%0d b=%0d tw=%0d, required 1 1 129 1",
                             name, rd_en, rd_addr_a, rd_addr_b, tw_addr);
                end
            end
            if (c == 3) begin
                checks++;
                if ({bf_en, wr_en, wr_addr_a, wr_addr_b} !== {1'b1, 1'b1, 8'd0, 8'd128}) begin
                    errors++;
                    $display("[TB] FAIL %s first_write: bf=%0b wr=%0b a=%0d b=%0d, required 1 1 0 128",
                             name, bf_en, wr_en, wr_addr_a, wr_addr_b);
                end
            end
            if (c == 129 || c == 130) begin
                checks++;
                if (rd_en !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s drain_c%0d: rd_en=%0b busy=%0b, required 0 1", name, c, rd_en, busy);
                end
            end
            if (c == 131) begin
                checks++;
                if (rd_en !== 1'b1 || stage !== 3'd1) begin
                    errors++;
                    $display("[TB] FAIL %s stage1_start: rd_en=%0b stage=%0d, required 1 1", name, rd_en, stage);
                end
            end
            if (c == 195) begin
                checks++;
                if ({rd_addr_a, rd_addr_b, tw_addr} !== {8'd128, 8'd192, 7'd0}) begin
                    errors++;
                    $display("[TB] FAIL %s s1_k64: a=%0d b=%0d tw=%0d, required 128 192 0",
                             name, rd_addr_a, rd_addr_b, tw_addr);
                end
            end
            if (c == 196) begin
                checks++;
                if (tw_addr !== 7'd2) begin
                    errors++;
                    $display("[TB] FAIL %s s1_k65_tw: tw=%0d, required 2", name, tw_addr);
                end
            end
            if (c == 911 || c == 912) begin
                checks++;
                if ({stage, rd_addr_a, rd_addr_b, tw_addr} !== {3'd7, 8'(2 * (c - 911)), 8'(2 * (c - 911) + 1), 7'd0}) begin
                    errors++;
                    $display("[TB] FAIL %s s7_pair_c%0d: stage=%0d a=%0d b=%0d tw=%0d, required 7 %0d %0d 0",
                             name, c, stage, rd_addr_a, rd_addr_b, tw_addr, 2 * (c - 911), 2 * (c - 911) + 1);
                end
            end
            if (c == DONE_C) begin
                checks++;
                if (done !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s done_cycle: done=%0b busy=%0b, required 1 1", name, done, busy);
                end
            end
            if (c == DONE_C + 2) begin
                checks++;
                if (busy !== hold || rd_en !== hold) begin
                    errors++;
                    $display("[TB] FAIL %s after_done: busy=%0b rd_en=%0b, required %0b %0b",
                             name, busy, rd_en, hold, hold);
                end
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL %s trace: %0d bad cycles (first at %0d), required 0", name, bad, first_bad);
        end
        checks++;
        if (wr_cnt !== (hold ? 1025 : 1024)) begin
            errors++;
            $display("[TB] FAIL %s wr_count: %0d, required %0d", name, wr_cnt, hold ? 1025 : 1024);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL %s done_count: %0d, required 1", name, done_cnt);
        end
        start = 1'b0;
    endtask

    task automatic test_full_transform();
        run_trace(1'b0, "full");
    endtask

    task automatic test_async_reset();
        int stray = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (440) @(posedge clk);
        #1;
        checks++;
        if (stage !== 3'd3 || rd_en !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_abort: stage=%0d rd_en=%0b, required 3 1", stage, rd_en);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, bf_en, wr_en, wr_addr_a, wr_addr_b} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: busy=%0b stage=%0d rd_en=%0b a=%0d b=%0d wr_en=%0b, required all 0",
                     busy, stage, rd_en, rd_addr_a, rd_addr_b, wr_en);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (wr_en !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("[TB] FAIL post_abort_quiet: %0d active cycles, required 0", stray);
        end
        run_trace(1'b0, "post_abort");
    endtask

    task automatic test_back_to_back();
        run_trace(1'b1, "b2b");
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_rd_lat1();
        logic       prev_en = 1'b0;
        logic [7:0] prev_a = '0, prev_b = '0;
        int done_at = -1, wr_cnt = 0, bad = 0;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int c = 1; c <= 1100 && done_at < 0; c++) begin
            if ({wr_en1, bf_en1, wr_addr_a1, wr_addr_b1} !== {prev_en, prev_en, prev_a, prev_b}) bad++;
            if (wr_en1 === 1'b1) wr_cnt++;
            if (done1 === 1'b1) done_at = c;
            prev_en = rd_en1; prev_a = rd_addr_a1; prev_b = rd_addr_b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (done_at !== 1033) begin
            errors++;
            $display("[TB] FAIL lat1_done_cycle: %0d, required 1033", done_at);
        end
        checks++;
        if (wr_cnt !== 1024) begin
            errors++;
            $display("[TB] FAIL lat1_wr_count: %0d, required 1024", wr_cnt);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("[TB] FAIL lat1_pipeline: %0d misaligned cycles, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_full_transform();
        test_async_reset();
        test_back_to_back();
        test_rd_lat1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
